// File: rtl/dot_product_stream.sv
// Streaming fixed-point dot product: LANES products per accepted beat are
// accumulated at full precision over N/LANES beats, then rounded, rescaled by
// FRAC bits and saturated or wrapped to WIDTH bits.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      beat on in_a/in_b is valid
//   in_ready      block accepts a beat this cycle (state only)
//   in_a, in_b    LANES packed signed elements, lane k at [k*WIDTH +: WIDTH]
//   sat_en        1 = saturate, 0 = wrap; sampled on the final beat only
//   out_valid     result held valid
//   out_ready     consumer accepts result
//   out_result    signed rounded, scaled dot product
//   out_overflow  scaled value was outside the signed WIDTH range
module dot_product_stream #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 2 * WIDTH + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic                     sat_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_overflow
);

    localparam int unsigned BEATS   = N / LANES;
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;
    // One guard bit so the rounding add can never wrap.
    localparam int unsigned SW      = ACC_W + 1;
    localparam int unsigned FRAC_M1 = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [SW-1:0] RND  = (FRAC > 0) ? (SW'(1) << FRAC_M1) : '0;
    localparam logic signed [SW-1:0] RMAX = (SW'(1) << (WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] RMIN = -(SW'(1) << (WIDTH - 1));

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         beat_cnt;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  beat_sum_c;
    logic signed [ACC_W-1:0]  fin_sum_c;
    logic signed [SW-1:0]     scaled_c;
    logic [WIDTH-1:0]         res_c;
    logic                     ovf_c;
    logic                     accept_c;
    logic                     last_c;

    // Per-beat lane products and the running total including this beat.
    always_comb begin
        prod_c     = '0;
        beat_sum_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            prod_c     = $signed(in_a[k*WIDTH +: WIDTH]) * $signed(in_b[k*WIDTH +: WIDTH]);
            beat_sum_c = beat_sum_c + ACC_W'(prod_c);
        end
        fin_sum_c = acc + beat_sum_c;
    end

    // Round half toward +inf, rescale, then range-check and clamp or wrap.
    always_comb begin
        scaled_c = ($signed({fin_sum_c[ACC_W-1], fin_sum_c}) + RND) >>> FRAC;
        ovf_c    = (scaled_c > RMAX) || (scaled_c < RMIN);
        res_c    = scaled_c[WIDTH-1:0];
        if (sat_en) begin
            if (scaled_c > RMAX) begin
                res_c = RMAX[WIDTH-1:0];
            end else if (scaled_c < RMIN) begin
                res_c = RMIN[WIDTH-1:0];
            end
        end
    end

    assign accept_c = in_valid && in_ready;
    assign last_c   = (beat_cnt == CNT_W'(BEATS - 1));

    // Control FSM, accumulator and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            beat_cnt     <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        if (last_c) begin
                            state        <= OUT;
                            acc          <= '0;
                            beat_cnt     <= '0;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_result   <= res_c;
                            out_overflow <= ovf_c;
                        end else begin
                            acc      <= fin_sum_c;
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
